// File: rtl/ex_stage_if.sv
// ex_stage_if -- bundle of the ID/EX inputs and EX/WB outputs of the execute stage.
//   master: upstream side, drives the instruction fields and observes the results.
//   slave : the execute stage itself.
//   aluSig_in[2:0] opcode, WB_in write-back enable, R1_in/R2_in[7:0] operands,
//   rd_in[4:0] destination; result_out[7:0], WB_out, rd_out[4:0], zero_out, stall.
interface ex_stage_if;
    logic [2:0] aluSig_in;
    logic       WB_in;
    logic [7:0] R1_in;
    logic [7:0] R2_in;
    logic [4:0] rd_in;
    logic [7:0] result_out;
    logic       WB_out;
    logic [4:0] rd_out;
    logic       zero_out;
    logic       stall;

    modport master (
        output aluSig_in, WB_in, R1_in, R2_in, rd_in,
        input  result_out, WB_out, rd_out, zero_out, stall
    );

    modport slave (
        input  aluSig_in, WB_in, R1_in, R2_in, rd_in,
        output result_out, WB_out, rd_out, zero_out, stall
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage -- pipeline execute stage with EX/WB output register.
//   Single-cycle ALU ops (ADD, SUB, AND, OR, XOR, SLT, SLL) register their
//   result one edge after capture. MUL (opcode 111) runs an 8-step shift-add
//   multiplier, holding stall high for the 8 cycles it occupies the stage.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - ex_stage_if.slave carrying instruction inputs and registered outputs
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;
    localparam logic [2:0] OP_MUL  = 3'b111;

    logic [0:0] state_reg;
    logic [2:0] cnt_reg;
    logic [7:0] acc_reg;
    logic [7:0] mcand_reg;
    logic [7:0] mplier_reg;
    logic       wb_lat_reg;
    logic [4:0] rd_lat_reg;
    logic [7:0] result_reg;
    logic       wb_reg;
    logic [4:0] rd_reg;
    logic       zero_reg;

    logic [7:0] alu_next;
    logic [7:0] addend;
    logic [7:0] acc_next;

    // Single-cycle ALU. Opcode 111 is handled by the sequencer; its value here is unused.
    always_comb begin
        alu_next = 8'h00;
        case (bus.aluSig_in)
            3'b000:  alu_next = bus.R1_in + bus.R2_in;
            3'b001:  alu_next = bus.R1_in - bus.R2_in;
            3'b010:  alu_next = bus.R1_in & bus.R2_in;
            3'b011:  alu_next = bus.R1_in | bus.R2_in;
            3'b100:  alu_next = bus.R1_in ^ bus.R2_in;
            3'b101:  alu_next = {7'd0, ($signed(bus.R1_in) < $signed(bus.R2_in))};
            3'b110:  alu_next = bus.R1_in << bus.R2_in[2:0];
            default: alu_next = 8'h00;
        endcase
    end

    // Partial product for this step: multiplicand gated by the multiplier LSB.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    // Only the low 8 bits of the product are kept, so overflow falls off here.
    assign acc_next = acc_reg + addend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 3'd0;
            acc_reg    <= 8'h00;
            mcand_reg  <= 8'h00;
            mplier_reg <= 8'h00;
            wb_lat_reg <= 1'b0;
            rd_lat_reg <= 5'd0;
            result_reg <= 8'h00;
            wb_reg     <= 1'b0;
            rd_reg     <= 5'd0;
            zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.aluSig_in == OP_MUL) begin
                        // Capture edge: latch the instruction and emit a bubble.
                        mcand_reg  <= bus.R1_in;
                        mplier_reg <= bus.R2_in;
                        wb_lat_reg <= bus.WB_in;
                        rd_lat_reg <= bus.rd_in;
                        cnt_reg    <= 3'd0;
                        acc_reg    <= 8'h00;
                        wb_reg     <= 1'b0;
                        state_reg  <= ST_MUL;
                    end else begin
                        result_reg <= alu_next;
                        wb_reg     <= bus.WB_in;
                        rd_reg     <= bus.rd_in;
                        zero_reg   <= (alu_next == 8'h00);
                    end
                end
                default: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 3'd1;
                    // Counter reads 7 on the eighth step; write back and release the stall.
                    if (cnt_reg == 3'd7) begin
                        result_reg <= acc_next;
                        zero_reg   <= (acc_next == 8'h00);
                        wb_reg     <= wb_lat_reg;
                        rd_reg     <= rd_lat_reg;
                        state_reg  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.result_out = result_reg;
    assign bus.WB_out     = wb_reg;
    assign bus.rd_out     = rd_reg;
    assign bus.zero_out   = zero_reg;
    assign bus.stall      = (state_reg == ST_MUL);
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage -- directed and randomized bench for ex_stage, checked against a
// cycle-level behavioural model (integer arithmetic plus a busy-cycle countdown).
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    ex_stage_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: expected outputs plus an outstanding multiply.
    int m_result = 0;
    int m_wb     = 0;
    int m_rd     = 0;
    int m_zero   = 0;
    int m_busy   = 0;
    int m_prod   = 0;
    int m_pwb    = 0;
    int m_prd    = 0;

    function automatic int ref_alu(input int op, input int a, input int b);
        int sa, sb;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (sa < sb) ? 1 : 0;
            6: return (a * (1 << (b % 8))) % 256;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: drive inputs, advance the model, then check every output.
    task automatic step(input logic r, input int op, input logic w,
                        input int a, input int b, input int d, input string tag);
        rst           = r;
        bus.aluSig_in = op[2:0];
        bus.WB_in     = w;
        bus.R1_in     = a[7:0];
        bus.R2_in     = b[7:0];
        bus.rd_in     = d[4:0];
        @(posedge clk);
        if (r) begin
            m_result = 0; m_wb = 0; m_rd = 0; m_zero = 0; m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_result = m_prod;
                m_zero   = (m_prod == 0);
                m_wb     = m_pwb;
                m_rd     = m_prd;
            end
        end else if (op == 7) begin
            m_prod = (a * b) % 256;
            m_pwb  = w;
            m_prd  = d;
            m_busy = 8;
            m_wb   = 0;
        end else begin
            m_result = ref_alu(op, a, b);
            m_zero   = (m_result == 0);
            m_wb     = w;
            m_rd     = d;
        end
        #1;
        chk({tag, ".result"}, 32'(bus.result_out), m_result);
        chk({tag, ".wb"},     32'(bus.WB_out),     m_wb);
        chk({tag, ".rd"},     32'(bus.rd_out),     m_rd);
        chk({tag, ".zero"},   32'(bus.zero_out),   m_zero);
        chk({tag, ".stall"},  32'(bus.stall),      (m_busy > 0) ? 1 : 0);
        $display("t=%0t %s rst=%0b op=%0d a=%02h b=%02h -> res=%02h wb=%0b rd=%0d z=%0b stall=%0b",
                 $time, tag, r, op, a[7:0], b[7:0], bus.result_out, bus.WB_out,
                 bus.rd_out, bus.zero_out, bus.stall);
    endtask

    initial begin
        bus.aluSig_in = 3'd0;
        bus.WB_in     = 1'b0;
        bus.R1_in     = 8'h00;
        bus.R2_in     = 8'h00;
        bus.rd_in     = 5'd0;

        step(1, 3, 1, 8'hAA, 8'h55, 7, "reset0");
        step(1, 7, 1, 8'h03, 8'h04, 3, "reset1");

        step(0, 0, 1, 8'h7F, 8'h01, 5, "add");
        chk("add_lit", 32'(bus.result_out), 32'h80);
        step(0, 1, 1, 8'h3C, 8'h3C, 2, "sub");
        chk("sub_lit_zero", 32'(bus.zero_out), 32'd1);
        step(0, 5, 1, 8'hFF, 8'h01, 3, "slt");
        chk("slt_lit", 32'(bus.result_out), 32'h01);
        step(0, 6, 1, 8'h11, 8'h0B, 4, "sll");
        chk("sll_lit", 32'(bus.result_out), 32'h88);
        step(0, 2, 0, 8'hF0, 8'h3C, 6, "and");
        step(0, 3, 1, 8'hF0, 8'h0F, 7, "or");
        step(0, 4, 1, 8'h5A, 8'h5A, 8, "xor");

        // Multiply with upstream holding ADD 2+3 until it is consumed at E9.
        step(0, 7, 1, 8'h0D, 8'h0B, 9, "mul_e0");
        for (int i = 1; i <= 8; i++) step(0, 0, 1, 8'h02, 8'h03, 12, "mul_hold");
        chk("mul_lit_res", 32'(bus.result_out), 32'h8F);
        chk("mul_lit_rd", 32'(bus.rd_out), 32'd9);
        step(0, 0, 1, 8'h02, 8'h03, 12, "mul_e9");
        chk("mul_e9_lit", 32'(bus.result_out), 32'h05);

        // Overflow to zero, then back-to-back with a WB=0 multiply.
        step(0, 7, 1, 8'h10, 8'h10, 1, "mulovf_e0");
        for (int i = 1; i <= 8; i++) step(0, 7, 0, 8'h03, 8'h05, 2, "mulovf_run");
        chk("mulovf_lit_zero", 32'(bus.zero_out), 32'd1);
        for (int i = 0; i <= 8; i++) step(0, 7, 0, 8'h03, 8'h05, 2, "mul_nowb");
        chk("mul_nowb_lit", 32'(bus.WB_out), 32'd0);

        // Reset during the fourth stall cycle aborts the multiply.
        step(0, 7, 1, 8'h07, 8'h06, 11, "mulrst_e0");
        for (int i = 1; i <= 3; i++) step(0, 0, 1, 8'h01, 8'h01, 3, "mulrst_run");
        step(1, 0, 1, 8'h01, 8'h01, 3, "mulrst_rst");
        chk("mulrst_lit_stall", 32'(bus.stall), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(0, 2, 0, 8'hFF, 8'h0F, 4, "mulrst_after");
            chk("mulrst_no_wb", 32'(bus.WB_out), 32'd0);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 40) == 0), $urandom_range(0, 7), 1'($urandom),
                 $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 31), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 aluSig_in  input  3  ALU operation code from the ID/EX register.
REQ-005 WB_in  input  1  register write-back enable for the incoming instruction.
REQ-006 R1_in  input  8  first operand.
REQ-007 R2_in  input  8  second operand.
REQ-008 rd_in  input  5  destination register index.
REQ-009 result_out  output  8  registered ALU result (EX/WB register).
REQ-010 WB_out  output  1  registered write-back enable; 0 denotes a bubble.
REQ-011 rd_out  output  5  registered destination index.
REQ-012 zero_out  output  1  registered flag, 1 when result_out == 8'h00.
REQ-013 stall  output  1  registered; 1 instructs upstream stages and the ID/EX register to hold their contents.

Function
REQ-014 State machine SHALL have two states: IDLE and MUL; stall SHALL equal (state == MUL).
REQ-015 In IDLE, each rising edge SHALL register result_out = f(aluSig_in, R1_in, R2_in), WB_out = WB_in, rd_out = rd_in, and zero_out = (f == 0), giving 1-cycle latency.
REQ-016 Opcode 000 ADD SHALL compute R1 + R2 mod 256.
REQ-017 Opcode 001 SUB SHALL compute R1 - R2 mod 256.
REQ-018 Opcodes 010 AND, 011 OR and 100 XOR SHALL be bitwise.
REQ-019 Opcode 101 SLT SHALL return 8'h01 if R1 < R2 as signed two's complement, otherwise 8'h00.
REQ-020 Opcode 110 SLL SHALL compute R1 << R2[2:0]; R2[7:3] SHALL be ignored.
REQ-021 Opcode 111 MUL in IDLE SHALL, at the capture edge E0, latch R1, R2, WB_in and rd_in, clear a 3-bit iteration counter, clear the accumulator, drive WB_out to 0 and enter MUL.
REQ-022 In MUL, each edge SHALL perform one shift-add step: add the multiplicand to the accumulator if the multiplier LSB is 1, shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter.
REQ-023 MUL SHALL perform exactly 8 steps on edges E1..E8; the result SHALL be the low 8 bits of the product, with overflow discarded.
REQ-024 At E8 the block SHALL register result_out = product[7:0], zero_out, WB_out = latched WB and rd_out = latched rd, and SHALL return to IDLE.
REQ-025 On edges E1..E7, WB_out SHALL be 0; result_out, rd_out and zero_out SHALL hold their E0 values.
REQ-026 stall SHALL be 1 for exactly the 8 cycles between E0 and E8 and 0 otherwise.
REQ-027 While in MUL, all *_in ports SHALL be ignored.
REQ-028 The instruction presented while stall = 1 SHALL be consumed at the first edge after stall falls (E9).
REQ-029 A MUL with WB_in = 0 SHALL still take 8 steps and SHALL assert stall; it SHALL complete with WB_out = 0.
REQ-030 Back-to-back MULs SHALL each take the full sequence, with the second captured at E9.

Reset
REQ-031 When rst = 1 at a rising edge, result_out, WB_out, rd_out, zero_out and stall SHALL all be 0, state SHALL be IDLE, and the counter and accumulator SHALL be cleared.
REQ-032 rst SHALL take priority over all operations; a reset mid-MUL SHALL abort it with no later write-back.
REQ-033 The first edge with rst = 0 SHALL process the inputs as in IDLE.

Verification
REQ-034 ADD test: R1=8'h7F, R2=8'h01, op 000, WB=1, rd=5 -> next cycle result_out=8'h80, WB_out=1, rd_out=5, zero_out=0, stall=0.
REQ-035 SUB test: R1=R2=8'h3C, op 001 -> result_out=8'h00, zero_out=1.
REQ-036 SLT/SLL test: op 101 with R1=8'hFF, R2=8'h01 -> 8'h01; then op 110 with R1=8'h11, R2=8'h0B -> 8'h88.
REQ-037 MUL test: R1=8'h0D, R2=8'h0B, WB=1, rd=9 at E0, with upstream then presenting ADD 8'h02+8'h03 held -> stall=1 for 8 cycles with WB_out=0; at E8 result_out=8'h8F, WB_out=1, rd_out=9; at E9 result_out=8'h05.
REQ-038 MUL overflow test: 8'h10 x 8'h10 -> result_out=8'h00, zero_out=1.
REQ-039 Reset test: rst=1 during the 4th stall cycle -> next edge all outputs 0, stall=0, and no MUL write-back afterwards.
